// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/grant/response bus
interface instr_fetch_unit_if #(
    parameter int PC_W = 32
);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage with stall/redirect; optional IFU_PERF_CNT_EN counters
module instr_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  imem,
    input  logic                id_stall,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [PC_W-1:0]     if_pc,
    output logic [6:0]          if_opcode
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall
`endif
);
    typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] redirect_target;
    logic            accept;
    logic            load;

    // Mask rather than slice so every redirect_pc bit feeds logic.
    assign redirect_target = redirect_pc & ~{{(PC_W-2){1'b0}}, 2'b11};

    // Issue rule, response acceptance and next state; redirect overrides everything.
    always_comb begin
        imem.req   = 1'b0;
        imem.addr  = pc;
        accept     = 1'b0;
        load       = 1'b0;
        state_next = state;
        if_opcode  = if_valid ? if_instr[6:0] : 7'b0000000;

        if (state == FETCH && !reset && (!if_valid || !id_stall)) begin
            imem.req = 1'b1;
        end
        accept = imem.req && imem.gnt;

        case (state)
            FETCH: begin
                if (accept) begin
                    state_next = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    state_next = FETCH;
                    load       = !redirect_valid;
                end else if (redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem.rvalid) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // State, PC and the decode-facing output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc       <= redirect_target;
                if_valid <= 1'b0;
            end else if (load) begin
                pc       <= pc + PC_W'(4);
                if_valid <= 1'b1;
                if_instr <= imem.rdata;
                if_pc    <= pc;
            end else if (if_valid && !id_stall) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Saturating counts of delivered instructions and decode back-pressure cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (load && perf_fetched != 32'hFFFF_FFFF) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (if_valid && id_stall && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage feeding the decoder: holds the program counter, issues one-at-a-time requests to instruction memory over a request/grant/response handshake, and registers each returned 32-bit instruction with its PC. Its `if_opcode` output drives the control unit's `opcode` input directly. It also supports decode-side stall and branch/jump redirect with flush.

## Interface
- `PC_W`, 32: program counter / instruction address width (≥3).
- `RESET_PC`, 0: PC value loaded on reset; low two bits must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  request valid to instruction memory.
- `imem_addr`  out  PC_W  word-aligned fetch address (`[1:0]`=0).
- `imem_gnt`  in  1  memory accepted request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  instruction word.
- `id_stall`  in  1  decode cannot accept; hold output register.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  PC_W  target; bits `[1:0]` ignored (treated as 0).
- `if_valid`  out  1  `if_instr` / `if_pc` hold a live instruction.
- `if_instr`  out  32  registered instruction.
- `if_pc`  out  PC_W  address of `if_instr`.
- `if_opcode`  out  7  `if_instr[6:0]` when `if_valid`, else 7'b0000000.
- `perf_fetched`, `perf_stall`  out  32 each  present only with `IFU_PERF_CNT_EN`.

## Operation
- FSM states: FETCH, WAIT, DROP. Reset state FETCH.
- FETCH: `imem_req`=1 with `imem_addr`=`pc` only when the output register is free or being consumed (`!if_valid || !id_stall`). `imem_gnt` with `imem_req` moves to WAIT. No grant: stay; `imem_addr` stays stable while `imem_req` is high.
- WAIT: `imem_req`=0. On `imem_rvalid`: load `if_instr`←`imem_rdata`, `if_pc`←`pc`, `if_valid`←1, `pc`←`pc`+4, go to FETCH.
- DROP: discard the in-flight response. On `imem_rvalid`, ignore the data and go to FETCH.
- Maximum one outstanding request. The issue rule above guarantees the output register is empty when a response arrives. There is no skid buffer.
- Consumption: `if_valid && !id_stall` at an edge clears `if_valid` unless a new response loads it in the same cycle.
- Redirect (highest priority, any state): `pc`←`{redirect_pc[PC_W-1:2],2'b00}`, `if_valid`←0.
  - From FETCH: stay in FETCH. A grant in that same cycle is treated as in-flight, so go to DROP.
  - From WAIT without `imem_rvalid`: go to DROP.
  - From WAIT with `imem_rvalid`: data discarded, go to FETCH.
  - From DROP with `imem_rvalid`: go to FETCH. Otherwise stay in DROP.
- PC arithmetic is modulo 2^PC_W; wrap from all-ones-aligned to 0 is silent.
- `if_opcode` forced to 0 when `!if_valid`, so the control unit decodes a bubble (no regwrite, no memwrite).

## Timing
- Reset values: `pc`=RESET_PC, state=FETCH, `if_valid`=0, `if_instr`=0, `if_pc`=0, `imem_req`=0 during reset cycle, perf counters=0.
- `imem_req` is asserted in the first cycle after reset deassertion.
- With zero-wait memory (gnt same cycle, rvalid next cycle): latency from request to `if_valid` is 2 edges. Throughput is one instruction per 2 cycles.
- Reset mid-operation discards any in-flight response. Memory is required to drop it too, since it shares the same reset.
- Outputs `imem_req`/`imem_addr`/`if_opcode` are combinational from registered state and `id_stall`. All other outputs are registered.

## Configuration
- `IFU_PERF_CNT_EN` defined:
  - `perf_fetched` increments on every accepted (non-dropped) response.
  - `perf_stall` increments each cycle `if_valid && id_stall`.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
  - Both clear on reset.
- Not defined: both ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, RESET_PC=0x100, memory gnt=1 and rvalid 1 cycle later returning 0x00500093 → first `if_pc`=0x100, `if_opcode`=0x13, next `imem_addr`=0x104.
- Hold `id_stall`=1 for 5 cycles with `if_valid`=1 → `if_instr`/`if_pc` unchanged, `imem_req`=0, no new request; `perf_stall`=5 with macro.
- `imem_gnt` low for 3 cycles → `imem_req` held, `imem_addr` stable, single grant produces a single response.
- `redirect_valid` with `redirect_pc`=0x203 while in WAIT, rvalid 2 cycles later → response discarded, `if_valid` stays 0, next `imem_addr`=0x200.
- Redirect in the same cycle as `imem_rvalid` → data discarded, FETCH next cycle at target; `perf_fetched` not incremented.
- PC=0xFFFFFFFC fetched → next `imem_addr`=0x00000000; `if_opcode`=0 whenever `if_valid`=0.
